// File: rtl/mgr_stu_upstream_arb_pkg.sv
// mgr_stu_upstream_arb_pkg: shared cntl/state encodings and default widths for the upstream stack-bus arbiter
package mgr_stu_upstream_arb_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_OOB_W  = 32;
  localparam int DEF_TYPE_W = 2;
  localparam int DEF_CNT_W  = 16;
  typedef enum logic [1:0] {MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SOM_EOM = 2'b11} cntl_e;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
endpackage

// File: rtl/mgr_stu_upstream_arb_if.sv
// mgr_stu_upstream_arb_if: per-channel upstream beats in, merged stack-bus beats out
//   ch__arb__valid/cntl/type/data/oob_data : NUM_CH packed source channels
//   arb__ch__ready                         : per-channel accept
//   mgr__stu__valid/cntl/type/data/oob_data: merged stack-bus beat
//   stu__mgr__ready                        : stack-bus accept
//   master = arbiter side, slave = sources + stack-bus sink
interface mgr_stu_upstream_arb_if import mgr_stu_upstream_arb_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OOB_W  = DEF_OOB_W,
  parameter int TYPE_W = DEF_TYPE_W
) ();
  logic [NUM_CH-1:0]        ch__arb__valid;
  logic [NUM_CH*2-1:0]      ch__arb__cntl;
  logic [NUM_CH*TYPE_W-1:0] ch__arb__type;
  logic [NUM_CH*DATA_W-1:0] ch__arb__data;
  logic [NUM_CH*OOB_W-1:0]  ch__arb__oob_data;
  logic [NUM_CH-1:0]        arb__ch__ready;
  logic                     mgr__stu__valid;
  logic [1:0]               mgr__stu__cntl;
  logic [TYPE_W-1:0]        mgr__stu__type;
  logic [DATA_W-1:0]        mgr__stu__data;
  logic [OOB_W-1:0]         mgr__stu__oob_data;
  logic                     stu__mgr__ready;
  modport master (
    input  ch__arb__valid, ch__arb__cntl, ch__arb__type, ch__arb__data, ch__arb__oob_data, stu__mgr__ready,
    output arb__ch__ready, mgr__stu__valid, mgr__stu__cntl, mgr__stu__type, mgr__stu__data, mgr__stu__oob_data
  );
  modport slave (
    output ch__arb__valid, ch__arb__cntl, ch__arb__type, ch__arb__data, ch__arb__oob_data, stu__mgr__ready,
    input  arb__ch__ready, mgr__stu__valid, mgr__stu__cntl, mgr__stu__type, mgr__stu__data, mgr__stu__oob_data
  );
endinterface

// File: rtl/mgr_stu_upstream_arb_skid_buf.sv
// mgr_stu_upstream_arb_skid_buf: 2-entry valid/ready register slice with registered head
//   clk, rst          : clock, sync active-high reset
//   i_valid/o_ready   : push side, o_ready = fewer than 2 entries held
//   i_data            : pushed word
//   o_valid/i_ready   : pop side, o_valid = non-empty
//   o_data            : head word, stable while o_valid & !i_ready
module mgr_stu_upstream_arb_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic [1:0]   r_cnt;
  logic [W-1:0] r_d0, r_d1;
  logic         w_push, w_pop;
  assign o_ready = ~r_cnt[1];
  assign o_valid = |r_cnt;
  assign o_data  = r_d0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  // push+pop only happens at one entry, so the new word goes straight to the head
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push && (r_cnt == 2'd0 || w_pop)) r_d0 <= i_data;
      else if (w_pop) r_d0 <= r_d1;
      if (w_push && r_cnt == 2'd1 && !w_pop) r_d1 <= i_data;
    end
endmodule

// File: rtl/mgr_stu_upstream_arb.sv
// mgr_stu_upstream_arb: round-robin, message-locked merge of NUM_CH upstream channels onto the stack bus
//   clk, reset_poweron : clock, sync active-high reset
//   stk                : channel inputs / stack-bus outputs (master modport)
//   arb__sys__protErr  : sticky per-channel protocol error
//   arb__sys__busy     : message locked or beats buffered
//   arb__sys__pktCount : EOM/SOM_EOM beats delivered, wrapping
module mgr_stu_upstream_arb import mgr_stu_upstream_arb_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OOB_W  = DEF_OOB_W,
  parameter int TYPE_W = DEF_TYPE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_poweron,
  mgr_stu_upstream_arb_if.master  stk,
  output logic [NUM_CH-1:0]       arb__sys__protErr,
  output logic                    arb__sys__busy,
  output logic [CNT_W-1:0]        arb__sys__pktCount
);
  localparam int PW = $clog2(NUM_CH);
  localparam int W  = 2 + TYPE_W + DATA_W + OOB_W;
  localparam logic [PW:0]   NCH  = (PW+1)'(NUM_CH);
  localparam logic [PW-1:0] LAST = PW'(NUM_CH - 1);
  state_e            r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr, r_lock, w_grant, w_sel;
  logic [PW:0]       w_sum;
  logic              w_found, w_sv, w_can, w_acc, w_push, w_err, w_pop;
  logic [1:0]        w_cntl;
  logic [W-1:0]      w_din, w_dout;
  logic [NUM_CH-1:0] r_err;
  logic [CNT_W-1:0]  r_cnt;
  // first valid channel at or after r_ptr, wrapping modulo NUM_CH
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    w_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_sum = (w_sum >= NCH) ? w_sum - NCH : w_sum;
      if (!w_found && stk.ch__arb__valid[w_sum[PW-1:0]]) begin
        w_grant = w_sum[PW-1:0];
        w_found = 1'b1;
      end
    end
  end
  assign w_sel  = (r_state == LOCKED) ? r_lock : w_grant;
  assign w_sv   = stk.ch__arb__valid[w_sel];
  assign w_cntl = stk.ch__arb__cntl[int'(w_sel)*2 +: 2];
  assign w_acc  = w_sv & w_can & ~reset_poweron;
  assign w_din  = {w_cntl, stk.ch__arb__type[int'(w_sel)*TYPE_W +: TYPE_W],
                   stk.ch__arb__data[int'(w_sel)*DATA_W +: DATA_W], stk.ch__arb__oob_data[int'(w_sel)*OOB_W +: OOB_W]};
  always_ff @(posedge clk)
    if (reset_poweron) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_lock  <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) r_lock <= w_grant;
      if (w_acc && w_state_nxt == IDLE) r_ptr <= (w_sel == LAST) ? '0 : w_sel + 1'b1;
      r_err <= r_err | ({{(NUM_CH-1){1'b0}}, w_err} << w_sel);
      if (w_pop && w_dout[W-1]) r_cnt <= r_cnt + 1'b1;
    end
  always_comb begin
    w_state_nxt = !w_acc ? r_state
                : (r_state == IDLE) ? ((w_cntl == SOM) ? LOCKED : IDLE)
                : ((w_cntl == EOM) ? IDLE : LOCKED);
  end
  // cntl[0] marks a start beat: a start inside a message or a non-start outside one is an error;
  // only non-start beats in IDLE are dropped
  always_comb begin
    stk.arb__ch__ready = {{(NUM_CH-1){1'b0}}, w_can & ~reset_poweron} << w_sel;
    w_push = w_acc & ~((r_state == IDLE) & ~w_cntl[0]);
    w_err  = w_acc & (w_cntl[0] == (r_state == LOCKED));
  end
  mgr_stu_upstream_arb_skid_buf #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (reset_poweron),
    .i_valid (w_push),
    .o_ready (w_can),
    .i_data  (w_din),
    .o_valid (stk.mgr__stu__valid),
    .i_ready (stk.stu__mgr__ready),
    .o_data  (w_dout)
  );
  assign w_pop = stk.mgr__stu__valid & stk.stu__mgr__ready;
  assign {stk.mgr__stu__cntl, stk.mgr__stu__type, stk.mgr__stu__data, stk.mgr__stu__oob_data} = w_dout;
  assign arb__sys__protErr  = r_err;
  assign arb__sys__busy     = (r_state == LOCKED) | stk.mgr__stu__valid;
  assign arb__sys__pktCount = r_cnt;
endmodule
